// File: rtl/khu_sensor_pkg.sv
// Shared types and defaults for the khu_sensor data path.
// Holds the scheduler state encoding, the source identifier, packet header
// bytes and the default payload sizes used by sensor_uart_scheduler.
package khu_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CKSUM
  } sched_state_t;

  typedef enum logic {
    SRC_ADS,
    SRC_MPR
  } src_t;

  localparam int unsigned ADS_BYTES_DEF = 9;
  localparam int unsigned MPR_BYTES_DEF = 2;
  localparam logic [7:0]  ADS_HDR_DEF   = 8'hA1;
  localparam logic [7:0]  MPR_HDR_DEF   = 8'hB2;
  localparam int unsigned DROP_W_DEF    = 8;

  // Payload byte index width; supports packets of up to 16 payload bytes.
  localparam int unsigned IDX_W = 4;

endpackage

// File: rtl/sample_slot.sv
// Per-source sample buffer for the UART scheduler.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        one-cycle strobe: load data_i into the capture register
//   data_i         sample, byte 0 in the most significant position
//   grant_i        scheduler grants this source: capture -> tx register
//   idx_i          payload byte index to present on byte_o
//   pending_o      capture register holds an untransmitted sample
//   byte_o         tx register byte idx_i (byte 0 = MSB)
//   drop_cnt_o     saturating count of overwritten pending samples
module sample_slot #(
  parameter int unsigned BYTES  = 2,
  parameter int unsigned DROP_W = 8,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [8*BYTES-1:0]   data_i,
  input  logic                 grant_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic                 pending_o,
  output logic [7:0]           byte_o,
  output logic [DROP_W-1:0]    drop_cnt_o
);

  logic [8*BYTES-1:0] cap_q, cap_d;
  logic [8*BYTES-1:0] tx_q, tx_d;
  logic               pend_q, pend_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [8*BYTES-1:0] shifted;

  always_comb begin
    cap_d  = valid_i ? data_i : cap_q;
    // tx takes the old capture; a coincident strobe keeps the slot pending.
    tx_d   = grant_i ? cap_q : tx_q;
    pend_d = grant_i ? valid_i : (pend_q | valid_i);
    drop_d = drop_q;
    if (valid_i && pend_q && !grant_i && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_q  <= '0;
      tx_q   <= '0;
      pend_q <= 1'b0;
      drop_q <= '0;
    end else begin
      cap_q  <= cap_d;
      tx_q   <= tx_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  // Shift the selected byte up into the MSB position.
  always_comb begin
    shifted = tx_q << {idx_i, 3'b000};
    byte_o  = shifted[8*BYTES-1 -: 8];
  end

  assign pending_o  = pend_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: rtl/sensor_uart_scheduler.sv
// Round-robin scheduler sharing one UART TX byte channel between the
// ADS1292 (ECG) and MPR121 (touch) front-ends. Each winning sample is sent
// as: header, payload bytes MSB-first, XOR checksum of all previous bytes.
// Ports:
//   i_CLK, i_RST          clock, asynchronous active-high reset
//   i_EN                  low blocks new grants (packet in flight completes)
//   i_ADS_VALID/_DATA     ADS1292 sample strobe and data
//   i_MPR_VALID/_DATA     MPR121 sample strobe and data
//   o_UART_DATA/_VALID    byte to UART transmitter, valid/ready handshake
//   i_UART_READY          transmitter accepts the byte
//   o_BUSY                packet in progress
//   o_ADS/MPR_DROP_CNT    saturating overrun counters
module sensor_uart_scheduler
  import khu_sensor_pkg::*;
#(
  parameter int unsigned ADS_BYTES = ADS_BYTES_DEF,
  parameter int unsigned MPR_BYTES = MPR_BYTES_DEF,
  parameter logic [7:0]  ADS_HDR   = ADS_HDR_DEF,
  parameter logic [7:0]  MPR_HDR   = MPR_HDR_DEF,
  parameter int unsigned DROP_W    = DROP_W_DEF
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_EN,
  input  logic                   i_ADS_VALID,
  input  logic [8*ADS_BYTES-1:0] i_ADS_DATA,
  input  logic                   i_MPR_VALID,
  input  logic [8*MPR_BYTES-1:0] i_MPR_DATA,
  output logic [7:0]             o_UART_DATA,
  output logic                   o_UART_VALID,
  input  logic                   i_UART_READY,
  output logic                   o_BUSY,
  output logic [DROP_W-1:0]      o_ADS_DROP_CNT,
  output logic [DROP_W-1:0]      o_MPR_DROP_CNT
);

  sched_state_t     state_q, state_d;
  src_t             src_q, src_d;
  src_t             last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       ck_q, ck_d;

  logic             ads_pend, mpr_pend;
  logic             ads_grant, mpr_grant;
  logic [7:0]       ads_byte, mpr_byte;
  logic [7:0]       cur_byte, hdr;
  logic [IDX_W-1:0] last_idx;

  sample_slot #(.BYTES(ADS_BYTES), .DROP_W(DROP_W), .IDX_W(IDX_W)) u_ads_slot (
    .clk_i      (i_CLK),
    .rst_i      (i_RST),
    .valid_i    (i_ADS_VALID),
    .data_i     (i_ADS_DATA),
    .grant_i    (ads_grant),
    .idx_i      (idx_q),
    .pending_o  (ads_pend),
    .byte_o     (ads_byte),
    .drop_cnt_o (o_ADS_DROP_CNT)
  );

  sample_slot #(.BYTES(MPR_BYTES), .DROP_W(DROP_W), .IDX_W(IDX_W)) u_mpr_slot (
    .clk_i      (i_CLK),
    .rst_i      (i_RST),
    .valid_i    (i_MPR_VALID),
    .data_i     (i_MPR_DATA),
    .grant_i    (mpr_grant),
    .idx_i      (idx_q),
    .pending_o  (mpr_pend),
    .byte_o     (mpr_byte),
    .drop_cnt_o (o_MPR_DROP_CNT)
  );

  assign hdr      = (src_q == SRC_ADS) ? ADS_HDR : MPR_HDR;
  assign cur_byte = (src_q == SRC_ADS) ? ads_byte : mpr_byte;
  assign last_idx = (src_q == SRC_ADS) ? IDX_W'(ADS_BYTES - 1) : IDX_W'(MPR_BYTES - 1);

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_d       = last_q;
    idx_d        = idx_q;
    ck_d         = ck_q;
    ads_grant    = 1'b0;
    mpr_grant    = 1'b0;
    o_UART_VALID = 1'b0;
    o_UART_DATA  = '0;
    unique case (state_q)
      IDLE: begin
        if (i_EN && (ads_pend || mpr_pend)) begin
          // ADS wins when alone or when MPR was served last.
          if (ads_pend && (!mpr_pend || last_q == SRC_MPR)) begin
            ads_grant = 1'b1;
            src_d     = SRC_ADS;
          end else begin
            mpr_grant = 1'b1;
            src_d     = SRC_MPR;
          end
          last_d  = src_d;
          idx_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        o_UART_VALID = 1'b1;
        o_UART_DATA  = hdr;
        if (i_UART_READY) begin
          ck_d    = hdr;
          idx_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        o_UART_VALID = 1'b1;
        o_UART_DATA  = cur_byte;
        if (i_UART_READY) begin
          ck_d = ck_q ^ cur_byte;
          if (idx_q == last_idx) begin
            state_d = CKSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CKSUM: begin
        o_UART_VALID = 1'b1;
        o_UART_DATA  = ck_q;
        if (i_UART_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      src_q   <= SRC_ADS;
      last_q  <= SRC_MPR;
      idx_q   <= '0;
      ck_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ck_q    <= ck_d;
    end
  end

  assign o_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_uart_scheduler.sv
module tb_sensor_uart_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        ads_v = 1'b0;
  logic [71:0] ads_d = '0;
  logic        mpr_v = 1'b0;
  logic [15:0] mpr_d = '0;
  logic [7:0]  u_data;
  logic        u_valid;
  logic        u_ready = 1'b1;
  logic        busy;
  logic [7:0]  ads_drop, mpr_drop;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0]  sb[$];

  sensor_uart_scheduler #(
    .ADS_BYTES(9),
    .MPR_BYTES(2),
    .ADS_HDR  (8'hA1),
    .MPR_HDR  (8'hB2),
    .DROP_W   (8)
  ) dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_EN          (en),
    .i_ADS_VALID   (ads_v),
    .i_ADS_DATA    (ads_d),
    .i_MPR_VALID   (mpr_v),
    .i_MPR_DATA    (mpr_d),
    .o_UART_DATA   (u_data),
    .o_UART_VALID  (u_valid),
    .i_UART_READY  (u_ready),
    .o_BUSY        (busy),
    .o_ADS_DROP_CNT(ads_drop),
    .o_MPR_DROP_CNT(mpr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted byte must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && u_valid && u_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got %02h expected none", u_data);
        end else begin
          chk("uart_byte", {24'h0, u_data}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; ads_v = 1'b0; mpr_v = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic strobe(input logic av, input logic [71:0] ad, input logic mv, input logic [15:0] md);
    @(posedge clk); #1;
    ads_v = av; ads_d = ad; mpr_v = mv; mpr_d = md;
    @(posedge clk); #1;
    ads_v = 1'b0; mpr_v = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while (sb.size() != 0 && n < 400);
    chk(name, 32'(sb.size()), 0);
    chk({name, "_idle"}, {31'h0, busy}, 0);
  endtask

  task automatic wait_byte(input string name, input logic [7:0] b);
    logic found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (u_valid && u_data == b) found = 1'b1;
    end
    chk(name, {31'h0, found}, 1);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", {31'h0, u_valid}, 0);
    chk("rst_data", {24'h0, u_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_ads_drop", {24'h0, ads_drop}, 0);
    chk("rst_mpr_drop", {24'h0, mpr_drop}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // MPR only, with latency check
    sb = {sb, 8'hB2, 8'h01, 8'h03, 8'hB0};
    @(posedge clk); #1;
    mpr_v = 1'b1; mpr_d = 16'h0103;
    @(negedge clk);
    chk("lat_c0", {31'h0, u_valid}, 0);
    @(posedge clk); #1 mpr_v = 1'b0;
    @(negedge clk);
    chk("lat_c1", {31'h0, u_valid}, 0);
    @(negedge clk);
    chk("lat_c2", {31'h0, u_valid}, 1);
    drain("mpr_only");

    // ADS only, all-zero payload
    sb = {sb, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1};
    strobe(1'b1, 72'h0, 1'b0, 16'h0);
    drain("ads_only");

    // Tie after reset: ADS first; second tie during the ADS packet favours MPR.
    do_reset();
    sb = {sb, 8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hA0};
    sb = {sb, 8'hB2, 8'h0F, 8'h01, 8'hBC};
    sb = {sb, 8'hA1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5E};
    strobe(1'b1, 72'h01_02_03_04_05_06_07_08_09, 1'b1, 16'h1234);
    repeat (3) @(posedge clk);
    strobe(1'b1, 72'hFF_00_00_00_00_00_00_00_00, 1'b1, 16'h0F01);
    drain("tie_rr");
    chk("tie_mpr_drop", {24'h0, mpr_drop}, 1);
    chk("tie_ads_drop", {24'h0, ads_drop}, 0);

    // Backpressure on payload byte 3
    sb = {sb, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hB0};
    strobe(1'b1, 72'h11_22_33_44_55_66_77_88_99, 1'b0, 16'h0);
    wait_byte("bp_reach", 8'h44);
    u_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", {24'h0, u_data}, 32'h44);
      chk("bp_hold_valid", {31'h0, u_valid}, 1);
    end
    @(posedge clk); #1 u_ready = 1'b1;
    drain("backpressure");

    // Overrun of the MPR capture slot during an ADS packet
    do_reset();
    sb = {sb, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1};
    sb = {sb, 8'hB2, 8'h00, 8'h03, 8'hB1};
    strobe(1'b1, 72'h0, 1'b0, 16'h0);
    strobe(1'b0, 72'h0, 1'b1, 16'h0001);
    strobe(1'b0, 72'h0, 1'b1, 16'h0002);
    strobe(1'b0, 72'h0, 1'b1, 16'h0003);
    drain("overrun");
    chk("overrun_drop", {24'h0, mpr_drop}, 2);

    // Saturation with grants blocked by i_EN=0: 301 strobes -> 300 overruns
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 301; k++) begin
      @(posedge clk); #1;
      mpr_v = 1'b1;
      mpr_d = (k == 300) ? 16'h5A5A : 16'h00AA;
      if (k == 100) chk("sat_mid_drop", {24'h0, mpr_drop}, 99);
    end
    @(posedge clk); #1 mpr_v = 1'b0;
    chk("sat_no_grant", {31'h0, busy}, 0);
    chk("sat_drop", {24'h0, mpr_drop}, 255);
    chk("sat_ads_drop", {24'h0, ads_drop}, 0);
    sb = {sb, 8'hB2, 8'h5A, 8'h5A, 8'hB2};
    en = 1'b1;
    drain("sat_resume");

    // Reset mid-payload: packet abandoned, nothing pending afterwards
    sb = {sb, 8'hA1, 8'h10, 8'h20, 8'h30};
    strobe(1'b1, 72'h10_20_30_40_50_60_70_80_90, 1'b0, 16'h0);
    wait_byte("midrst_reach", 8'h30);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'h0, u_valid}, 0);
    chk("midrst_busy", {31'h0, busy}, 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    begin
      logic saw = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (u_valid) saw = 1'b1;
      end
      chk("midrst_no_packet", {31'h0, saw}, 0);
    end
    chk("midrst_drop", {24'h0, mpr_drop}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
